// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RISC-V sequencer: state encodings,
// opcode classes and the branch funct3 codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    BUSCA      = 4'b0000,
    DECODIFICA = 4'b0001,
    EXECUTA    = 4'b0010,
    MEMORIA    = 4'b0011,
    ESCRITA    = 4'b0100,
    FIM        = 4'b1111
  } estado_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // True for the five opcode classes the sequencer knows how to run.
  function automatic logic opcode_valido(logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/controle_pc_if.sv
// Bundle between the sequencer and the fetch stage / datapath.
interface controle_pc_if;
  logic [31:0] instrucao;
  logic        zero;
  logic [3:0]  estado;
  logic [31:0] PC;
  logic        escreve_reg;
  logic        le_mem;
  logic        escreve_mem;
  logic        fim;

  // Sequencer side.
  modport master (
    input  instrucao, zero,
    output estado, PC, escreve_reg, le_mem, escreve_mem, fim
  );

  // Fetch stage / datapath side.
  modport slave (
    output instrucao, zero,
    input  estado, PC, escreve_reg, le_mem, escreve_mem, fim
  );
endinterface

// File: rtl/gerador_imm_b.sv
// Combinational B-type immediate extractor: sign-extended byte offset.
module gerador_imm_b (
  input  logic [31:0] instrucao,
  output logic [31:0] imm_b
);

  // Bits outside the B-immediate fields are intentionally ignored here.
  logic unused_campos;
  assign unused_campos = ^{instrucao[24:12], instrucao[6:0]};

  assign imm_b = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                  instrucao[30:25], instrucao[11:8], 1'b0};

endmodule

// File: rtl/controle_pc.sv
// Multi-cycle sequencer and word-indexed program counter.
//
//   state      | meaning
//   BUSCA      | fetch samples instrucao at PC on the edge leaving this state
//   DECODIFICA | latch opcode/funct3/B-immediate, reject invalid classes
//   EXECUTA    | ALU phase; branches resolve here using zero
//   MEMORIA    | data-memory access for LOAD/STORE
//   ESCRITA    | register-file write-back
//   FIM        | halted until reset
module controle_pc
  import riscv_pkg::*;
#(
  parameter int NUM_INSTR = 4
) (
  input  logic          clk,
  input  logic          reset,
  controle_pc_if.master bus
);

  localparam logic [31:0] LIMITE = 32'(NUM_INSTR);

  estado_t     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [31:0] imm_q;
  logic [31:0] imm_b;

  logic        avanca;
  logic        desvio_tomado;
  logic        signed [31:0] deslocamento;
  logic [31:0] pc_cand;

  gerador_imm_b u_imm_b (
    .instrucao (bus.instrucao),
    .imm_b     (imm_b)
  );

  // Branch condition from the latched funct3 and the live ALU zero flag.
  always_comb begin
    desvio_tomado = 1'b0;
    if ((funct3_q == F3_BEQ) && bus.zero)
      desvio_tomado = 1'b1;
    else if ((funct3_q == F3_BNE) && !bus.zero)
      desvio_tomado = 1'b1;
  end

  // Word offset kept in its own signed variable so the shift stays arithmetic.
  always_comb begin
    deslocamento = $signed(imm_q) >>> 2;
  end

  // Next state and next PC; any PC advance past the program end halts instead.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    avanca  = 1'b0;
    pc_cand = pc_q + 32'd1;
    case (state_q)
      BUSCA:      state_d = DECODIFICA;
      DECODIFICA: state_d = opcode_valido(bus.instrucao[6:0]) ? EXECUTA : FIM;
      EXECUTA: begin
        case (opcode_q)
          OP_R, OP_I:        state_d = ESCRITA;
          OP_LOAD, OP_STORE: state_d = MEMORIA;
          OP_BRANCH: begin
            avanca = 1'b1;
            if (desvio_tomado)
              pc_cand = pc_q + $unsigned(deslocamento);
          end
          default:           state_d = FIM;
        endcase
      end
      MEMORIA: begin
        if (opcode_q == OP_LOAD)
          state_d = ESCRITA;
        else
          avanca = 1'b1;
      end
      ESCRITA:    avanca = 1'b1;
      FIM:        state_d = FIM;
      default:    state_d = FIM;
    endcase

    if (avanca) begin
      if (pc_cand >= LIMITE) begin
        state_d = FIM;
      end else begin
        state_d = BUSCA;
        pc_d    = pc_cand;
      end
    end
  end

  // State, PC and decoded-field registers; reset aborts any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BUSCA;
      pc_q     <= '0;
      opcode_q <= '0;
      funct3_q <= '0;
      imm_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == DECODIFICA) begin
        opcode_q <= bus.instrucao[6:0];
        funct3_q <= bus.instrucao[14:12];
        imm_q    <= imm_b;
      end
    end
  end

  assign bus.estado      = state_q;
  assign bus.PC          = pc_q;
  assign bus.escreve_reg = (state_q == ESCRITA);
  assign bus.le_mem      = (state_q == MEMORIA) && (opcode_q == OP_LOAD);
  assign bus.escreve_mem = (state_q == MEMORIA) && (opcode_q == OP_STORE);
  assign bus.fim         = (state_q == FIM);

endmodule
